// File: rtl/fazyrv_mem_resp.sv
// Strobe/ack on-chip memory for the core's instruction and data ports; one request in flight, data port wins ties.
// Latency: ack and read data registered, W+1 cycles after accept (W = WAIT_CYCLES, plus 0..3 when FAZYRV_MEM_RESP_STALL_EN is defined).
// Backpressure: other port's stb ignored until IDLE; dropping the served stb before ACK cancels the access with no ack and no write.
module fazyrv_mem_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        imem_stb_i,
    input  logic [31:0] imem_adr_i,
    output logic [31:0] imem_dat_o,
    output logic        imem_ack_o,
    input  logic        dmem_stb_i,
    input  logic        dmem_we_i,
    input  logic [3:0]  dmem_be_i,
    input  logic [31:0] dmem_adr_i,
    input  logic [31:0] dmem_dat_i,
    output logic [31:0] dmem_dat_o,
    output logic        dmem_ack_o,
    output logic        busy_o
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fazyrv_mem_resp: DEPTH must be a power of two >= 4");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("fazyrv_mem_resp: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            sel_d_q, sel_d_d;   // 1: serving the data port
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            enter_ack;
    logic            sel_stb;
    logic [4:0]      wait_total;
    logic [31:0]     rd_word;
    logic            do_write;

    logic [31:0]     mem [DEPTH];

    logic unused_adr;
    assign unused_adr = ^{imem_adr_i[31:AW+2], imem_adr_i[1:0],
                          dmem_adr_i[31:AW+2], dmem_adr_i[1:0]};

`ifdef FAZYRV_MEM_RESP_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Advances once per accept; the extra stall uses the value before the advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else if (state_q == S_IDLE && (dmem_stb_i || imem_stb_i)) begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end

    assign wait_total = 5'(WAIT_CYCLES) + {3'd0, lfsr_q[1:0]};
`else
    assign wait_total = 5'(WAIT_CYCLES);
`endif

    assign sel_stb = sel_d_q ? dmem_stb_i : imem_stb_i;
    assign busy_o  = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d_d   = sel_d_q;
        we_d      = we_q;
        idx_d     = idx_q;
        enter_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dmem_stb_i || imem_stb_i) begin
                    sel_d_d = dmem_stb_i;
                    we_d    = dmem_stb_i & dmem_we_i;
                    idx_d   = dmem_stb_i ? dmem_adr_i[AW+1:2] : imem_adr_i[AW+1:2];
                    cnt_d   = wait_total;
                    if (wait_total == 5'd0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    if (sel_stb) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ACK:   state_d = S_GAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Index/port come from the _d side so the zero-wait path reads the word being accepted.
    assign rd_word  = mem[idx_d];
    assign do_write = enter_ack & sel_d_d & we_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            sel_d_q    <= 1'b0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            imem_ack_o <= 1'b0;
            dmem_ack_o <= 1'b0;
            imem_dat_o <= 32'h0;
            dmem_dat_o <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_d_q    <= sel_d_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            imem_ack_o <= enter_ack & ~sel_d_d;
            dmem_ack_o <= enter_ack & sel_d_d;
            if (enter_ack && !sel_d_d) begin
                imem_dat_o <= rd_word;
            end
            if (enter_ack && sel_d_d && !we_d) begin
                dmem_dat_o <= rd_word;
            end
        end
    end

    // Memory has no reset; a reset edge only suppresses the pending write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_be_i[b]) begin
                    mem[idx_d][8*b +: 8] <= dmem_dat_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/fazyrv_mem_resp.md
# fazyrv_mem_resp

Single-clock memory responder for the core's instruction and data strobe/ack interface. It holds a word-organised on-chip memory, accepts one request at a time from the instruction port (`imem_*`) or the data port (`dmem_*`), and returns a one-cycle acknowledge after a programmable number of wait states. It serves as the on-chip program/data memory in small SoC builds and as the standard memory model in the core testbenches.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; must be a power of two ≥ 4.
- `WAIT_CYCLES`, 0: fixed wait states between accept and ack; legal range 0–15.
- `AW`, `$clog2(DEPTH)`: word-index width (derived; do not override).

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `imem_stb_i` in 1: instruction fetch request; held until ack or withdrawn.
- `imem_adr_i` in 32: byte address; word index `imem_adr_i[AW+1:2]`.
- `imem_dat_o` out 32: fetched word; valid while `imem_ack_o`=1.
- `imem_ack_o` out 1: one-cycle instruction acknowledge.
- `dmem_stb_i` in 1: data request; held until ack or withdrawn.
- `dmem_we_i` in 1: 1 = write, 0 = read.
- `dmem_be_i` in 4: byte enables for writes; bit n covers bits 8n+7:8n.
- `dmem_adr_i` in 32: byte address; word index `dmem_adr_i[AW+1:2]`.
- `dmem_dat_i` in 32: write data.
- `dmem_dat_o` out 32: read word; valid while `dmem_ack_o`=1.
- `dmem_ack_o` out 1: one-cycle data acknowledge.
- `busy_o` out 1: high in every state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, ACK, GAP. Reset → IDLE, wait counter = 0, both ack outputs 0, both data outputs 0x0000_0000. Memory contents are not reset; in simulation they initialise to zero.
- IDLE: if `dmem_stb_i`=1, latch port=D, `we`, and address. Otherwise, if `imem_stb_i`=1, latch port=I. Data has fixed priority.
- On accept, load counter with total wait `W`. Go to WAIT if `W`>0, otherwise go to ACK.
- WAIT: decrement the counter each cycle; on the cycle it reaches 1, go to ACK.
- Cancel: in IDLE→ACK or WAIT→ACK transitions, if the latched port's stb is 0, go to IDLE instead. No ack is issued and no write is performed. This supports the core aborting a data access.
- Entering ACK (same edge):
  - Read: the latched word is registered into the port's `dat_o`.
  - Write: bytes selected by the `dmem_be_i`/`dmem_dat_i` values sampled at that edge are committed. Writes with `dmem_be_i`=0 change nothing.
  - Imem is always a read. `dmem_we_i` is ignored for port I.
- ACK: the latched port's ack = 1 for exactly one cycle. The other port's ack stays 0. Next state is GAP.
- GAP: one cycle with stb ignored, covering the cycle in which the requester drops its strobe. Next state is IDLE.
- `dat_o` holds its last value outside ACK.
- Address bits above `AW+1` are ignored, so addresses wrap modulo `DEPTH*4`. Bits [1:0] are ignored.
- Reset asserted mid-request: the FSM goes to IDLE, acks go to 0, any pending write is dropped, and memory keeps its contents.

## Timing
- Stb first sampled high at the edge ending cycle k, in IDLE: ack is high in cycle k+1+W.
  - W=0 gives a single-cycle response.
- Minimum request-to-request spacing is W+3 cycles: accept, ACK, GAP, then IDLE.
- Ack and data outputs are registered, with no combinational path from stb to ack.
- Simultaneous `imem_stb_i` and `dmem_stb_i` in IDLE: data is served first. Instruction is served after GAP if its stb is still high.
- The stb of the port not being served is ignored until IDLE.

## Configuration
- `FAZYRV_MEM_RESP_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 0xACE1 on reset and advances once per accept.
  - Total wait is W = `WAIT_CYCLES` + `lfsr[1:0]` (0–3 extra cycles), sampled at accept before the advance.
- Not defined: the LFSR is absent and W = `WAIT_CYCLES` exactly.

## Test plan
- W=0: preload word 5 = 0xDEADBEEF. Hold `imem_stb_i`=1 with adr 0x14 in cycle 0 → `imem_ack_o`=1 and `imem_dat_o`=0xDEADBEEF in cycle 1 only; `busy_o` low again in cycle 3.
- `WAIT_CYCLES`=3: dmem write adr 0x20, be=4'b0101, dat=0x11223344 over old 0xAABBCCDD → ack in cycle 4; a subsequent read returns 0xAA22CC44.
- Both stb high in IDLE → `dmem_ack_o` precedes `imem_ack_o`; the imem ack arrives in cycle 1+W+2+1+W after the first.
- `WAIT_CYCLES`=4: drop `dmem_stb_i` in cycle 2 of a write → no ack at any time, memory unchanged, FSM back in IDLE.
- Address 0x1000 with `DEPTH`=1024 reads word 0 (wrap). Assert `rst_i` during WAIT → no ack, outputs 0, the next request behaves normally.
- With `FAZYRV_MEM_RESP_STALL_EN`: 100 sequential reads → every latency lies within [W+1, W+4] and the sequence matches the reference LFSR model.
